// File: rtl/fpu_pkg.sv
// Shared FPU constants and types: default significand-slice width and
// leading-zero count sizing used by the normalization stage.
package fpu_pkg;

    localparam int LZC_DEFAULT_WIDTH = 6;

    // A count must be able to hold the value WIDTH itself (all-zero operand).
    function automatic int lzcCountWidth(input int width);
        return $clog2(width + 1);
    endfunction

    typedef logic [lzcCountWidth(LZC_DEFAULT_WIDTH)-1:0] lzcCount_t;

endpackage

// File: rtl/nlc_leading_zero_counter_if.sv
// Operand/result bundle between the add/sub datapath and the leading-zero
// counter; master drives the operand, slave returns the registered count.
interface nlc_leading_zero_counter_if
    import fpu_pkg::*;
#(
    parameter int WIDTH = LZC_DEFAULT_WIDTH,
    parameter int CNT_W = lzcCountWidth(WIDTH)
) ();

    logic             in_valid;
    logic [WIDTH-1:0] ZAs;
    logic             out_valid;
    logic             allZeros;
    logic [CNT_W-1:0] NumberofZeros;

    modport master (
        output in_valid,
        output ZAs,
        input  out_valid,
        input  allZeros,
        input  NumberofZeros
    );

    modport slave (
        input  in_valid,
        input  ZAs,
        output out_valid,
        output allZeros,
        output NumberofZeros
    );

endinterface

// File: rtl/nlc_lzc_core.sv
// Combinational MSB-first priority encoder: number of leading zeros of
// i_zas plus an all-zero flag (count equals WIDTH exactly when all-zero).
module nlc_lzc_core
    import fpu_pkg::*;
#(
    parameter int WIDTH = LZC_DEFAULT_WIDTH,
    parameter int CNT_W = lzcCountWidth(WIDTH)
) (
    input  logic [WIDTH-1:0] i_zas,
    output logic [CNT_W-1:0] o_count,
    output logic             o_allZero
);

    // Scan upward so the highest set bit is the last one to overwrite the count.
    always_comb begin
        o_count   = CNT_W'(WIDTH);
        o_allZero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_zas[i]) begin
                o_count   = CNT_W'(WIDTH - 1 - i);
                o_allZero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nlc_leading_zero_counter.sv
// Registered leading-zero counter for the add/sub normalization stage:
// one-cycle latency, accepts an operand every cycle, async active-high reset.
module nlc_leading_zero_counter
    import fpu_pkg::*;
#(
    parameter int WIDTH = LZC_DEFAULT_WIDTH,
    parameter int CNT_W = lzcCountWidth(WIDTH)
) (
    input logic                     clk,
    input logic                     rst,
    nlc_leading_zero_counter_if.slave bus
);

    logic [CNT_W-1:0] w_count;
    logic             w_allZero;

    logic             r_outValid;
    logic             r_allZeros;
    logic [CNT_W-1:0] r_numberOfZeros;

    nlc_lzc_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .i_zas     (bus.ZAs),
        .o_count   (w_count),
        .o_allZero (w_allZero)
    );

    // Result registers only load on a valid operand, so an idle (possibly X)
    // operand never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid      <= 1'b0;
            r_allZeros      <= 1'b0;
            r_numberOfZeros <= '0;
        end else begin
            r_outValid <= bus.in_valid;
            if (bus.in_valid) begin
                r_allZeros      <= w_allZero;
                r_numberOfZeros <= w_count;
            end
        end
    end

    assign bus.out_valid     = r_outValid;
    assign bus.allZeros      = r_allZeros;
    assign bus.NumberofZeros = r_numberOfZeros;

endmodule

// File: tb/tb_nlc_leading_zero_counter.sv
// Directed self-checking bench for nlc_leading_zero_counter at the default
// width and at WIDTH=8/CNT_W=4.
module tb_nlc_leading_zero_counter;
    import fpu_pkg::*;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    nlc_leading_zero_counter_if #(.WIDTH(6), .CNT_W(3)) bus6 ();
    nlc_leading_zero_counter_if #(.WIDTH(8), .CNT_W(4)) bus8 ();

    nlc_leading_zero_counter #(.WIDTH(6), .CNT_W(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    nlc_leading_zero_counter #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference: shift left until the top bit is a one.
    function automatic int refLzc(input int w, input logic [31:0] v);
        int          n;
        logic [31:0] t;
        n = 0;
        t = v;
        while (n < w && t[w-1] == 1'b0) begin
            t = t << 1;
            n++;
        end
        return n;
    endfunction

    // Drive at the falling edge, let one rising edge capture, sample at the next fall.
    task automatic applyStimulus(input logic valid, input logic [5:0] zas);
        bus6.in_valid = valid;
        bus6.ZAs      = zas;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic az, input int n);
        checkVal({tag, ".out_valid"}, 32'(bus6.out_valid), 32'(v));
        checkVal({tag, ".allZeros"}, 32'(bus6.allZeros), 32'(az));
        checkVal({tag, ".NumberofZeros"}, 32'(bus6.NumberofZeros), 32'(n));
    endtask

    task automatic applyStimulus8(input logic valid, input logic [7:0] zas);
        bus8.in_valid = valid;
        bus8.ZAs      = zas;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput8(input string tag, input logic v, input logic az, input int n);
        checkVal({tag, ".out_valid"}, 32'(bus8.out_valid), 32'(v));
        checkVal({tag, ".allZeros"}, 32'(bus8.allZeros), 32'(az));
        checkVal({tag, ".NumberofZeros"}, 32'(bus8.NumberofZeros), 32'(n));
    endtask

    initial begin
        lzcCount_t expCount;
        compared   = 0;
        mismatched = 0;

        // Reset held with a valid operand present: outputs stay cleared.
        rst           = 1'b1;
        bus6.in_valid = 1'b1;
        bus6.ZAs      = 6'b000001;
        bus8.in_valid = 1'b0;
        bus8.ZAs      = '0;
        #1;
        checkOutput("reset_immediate", 1'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_held", 1'b0, 1'b0, 0);

        rst = 1'b0;
        applyStimulus(1'b1, 6'b000001);
        checkOutput("after_release", 1'b1, 1'b0, 5);

        // Hand-computed directed vectors.
        applyStimulus(1'b1, 6'b100000);
        checkOutput("vec_100000", 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 6'b011111);
        checkOutput("vec_011111", 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 6'b001010);
        checkOutput("vec_001010", 1'b1, 1'b0, 2);
        applyStimulus(1'b1, 6'b000100);
        checkOutput("vec_000100", 1'b1, 1'b0, 3);
        applyStimulus(1'b1, 6'b000011);
        checkOutput("vec_000011", 1'b1, 1'b0, 4);
        applyStimulus(1'b1, 6'b000001);
        checkOutput("vec_000001", 1'b1, 1'b0, 5);

        // All-zero followed back-to-back by all-ones.
        applyStimulus(1'b1, 6'b000000);
        checkOutput("all_zero", 1'b1, 1'b1, 6);
        applyStimulus(1'b1, 6'b111111);
        checkOutput("all_ones_b2b", 1'b1, 1'b0, 0);

        // Exhaustive sweep, one operand per cycle.
        for (int v = 0; v < 64; v++) begin
            applyStimulus(1'b1, 6'(v));
            expCount = lzcCount_t'(refLzc(6, 32'(v)));
            checkOutput($sformatf("sweep_%0d", v), 1'b1, (v == 0), int'(expCount));
        end

        // Hold: idle cycles keep the last result, even with X on the operand.
        applyStimulus(1'b1, 6'b000111);
        checkOutput("hold_load", 1'b1, 1'b0, 3);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 6'b100000);
            checkOutput($sformatf("hold_%0d", c), 1'b0, 1'b0, 3);
        end
        applyStimulus(1'b0, 6'bxxxxxx);
        checkOutput("hold_x_operand", 1'b0, 1'b0, 3);

        // Mid-stream reset pulsed between edges while a result is valid.
        applyStimulus(1'b1, 6'b000010);
        checkOutput("pre_midreset", 1'b1, 1'b0, 4);
        bus6.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_async", 1'b0, 1'b0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_no_spurious", 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 6'b010000);
        checkOutput("midreset_resume", 1'b1, 1'b0, 1);

        // Wider instance.
        bus6.in_valid = 1'b0;
        applyStimulus8(1'b1, 8'h01);
        checkOutput8("w8_01", 1'b1, 1'b0, 7);
        applyStimulus8(1'b1, 8'h00);
        checkOutput8("w8_00", 1'b1, 1'b1, 8);
        applyStimulus8(1'b1, 8'h80);
        checkOutput8("w8_80", 1'b1, 1'b0, 0);
        applyStimulus8(1'b1, 8'h1C);
        checkOutput8("w8_1C", 1'b1, 1'b0, 3);
        applyStimulus8(1'b0, 8'hFF);
        checkOutput8("w8_idle", 1'b0, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
